// File: rtl/axil_seq_tester_if.sv
`default_nettype none
// ============================================================================
//  Module   : axil_seq_tester_if
//  Purpose  : AXI4-Lite bus bundle used by the sequential register tester.
//             The master modport is used by the tester and the slave modport
//             by whatever sits on the other side of the bus.
//  Ports    : none (a signal bundle only)
//             Write address : M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID/AWREADY
//             Write data    : M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID/WREADY
//             Write response: M_AXI_BRESP, M_AXI_BVALID/BREADY
//             Read address  : M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID/ARREADY
//             Read data     : M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID/RREADY
//  Revision : 1.0 - initial release
// ============================================================================
interface axil_seq_tester_if #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
);
    logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [2:0]                      M_AXI_AWPROT;
    logic                            M_AXI_AWVALID;
    logic                            M_AXI_AWREADY;
    logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                            M_AXI_WVALID;
    logic                            M_AXI_WREADY;
    logic [1:0]                      M_AXI_BRESP;
    logic                            M_AXI_BVALID;
    logic                            M_AXI_BREADY;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [2:0]                      M_AXI_ARPROT;
    logic                            M_AXI_ARVALID;
    logic                            M_AXI_ARREADY;
    logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]                      M_AXI_RRESP;
    logic                            M_AXI_RVALID;
    logic                            M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface
`default_nettype wire

// File: rtl/axil_seq_tester.sv
`default_nettype none
// ============================================================================
//  Module   : axil_seq_tester
//  Purpose  : AXI4-Lite master that writes SEED+i to NUM_REGS consecutive
//             32-bit registers starting at BASE_ADDR, reads them all back and
//             counts data mismatches plus non-OKAY responses.
//  Ports    : ACLK      - clock, rising edge
//             ARESETN   - synchronous active-low reset
//             start     - one-cycle pulse, begins a run (ignored while busy)
//             busy      - run in progress
//             done      - one-cycle pulse at the end of a run
//             pass      - result of the last completed run
//             err_count - error count of the last run, saturating at 255
//             m_axi     - AXI4-Lite master bus
//  Revision : 1.0 - initial release
// ============================================================================
module axil_seq_tester #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter int                            NUM_REGS           = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = 32'h0000_0000,
    parameter logic [C_M_AXI_DATA_WIDTH-1:0] SEED               = 32'h0000_0001
) (
    input  wire logic         ACLK,
    input  wire logic         ARESETN,
    input  wire logic         start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    axil_seq_tester_if.master m_axi
);

    localparam int                 c_IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REGS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        FINISH  = 3'd5
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [c_IDX_W-1:0]              r_index;
    logic                            r_aw_done;
    logic                            r_w_done;
    logic [7:0]                      r_err_count;
    logic                            r_busy;
    logic                            r_pass;

    logic                            w_aw_hs;
    logic                            w_w_hs;
    logic                            w_wr_both;
    logic                            w_last;
    logic                            w_err_inc;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   w_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0]   w_exp_data;

    // Address and data of the register currently being exercised
    assign w_addr     = BASE_ADDR + (C_M_AXI_ADDR_WIDTH'(r_index) << 2);
    assign w_exp_data = SEED + C_M_AXI_DATA_WIDTH'(r_index);
    assign w_last     = (r_index == c_LAST_IDX);

    // Handshakes are derived from state so that the comb block below never
    // reads back its own outputs.
    assign w_aw_hs   = (r_state == WR_REQ) && !r_aw_done && m_axi.M_AXI_AWREADY;
    assign w_w_hs    = (r_state == WR_REQ) && !r_w_done  && m_axi.M_AXI_WREADY;
    // Both channels are complete once each has finished now or earlier
    assign w_wr_both = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

    assign m_axi.M_AXI_AWPROT = 3'b000;
    assign m_axi.M_AXI_ARPROT = 3'b000;
    assign m_axi.M_AXI_WSTRB  = '1;

    assign busy      = r_busy;
    assign pass      = r_pass;
    assign err_count = r_err_count;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt          = r_state;
        w_err_inc            = 1'b0;
        done                 = 1'b0;
        m_axi.M_AXI_AWVALID  = 1'b0;
        m_axi.M_AXI_AWADDR   = '0;
        m_axi.M_AXI_WVALID   = 1'b0;
        m_axi.M_AXI_WDATA    = '0;
        m_axi.M_AXI_BREADY   = 1'b0;
        m_axi.M_AXI_ARVALID  = 1'b0;
        m_axi.M_AXI_ARADDR   = '0;
        m_axi.M_AXI_RREADY   = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = WR_REQ;
                end
            end
            WR_REQ: begin
                m_axi.M_AXI_AWVALID = !r_aw_done;
                m_axi.M_AXI_WVALID  = !r_w_done;
                m_axi.M_AXI_AWADDR  = w_addr;
                m_axi.M_AXI_WDATA   = w_exp_data;
                if (w_wr_both) begin
                    w_state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                m_axi.M_AXI_BREADY = 1'b1;
                if (m_axi.M_AXI_BVALID) begin
                    w_err_inc   = (m_axi.M_AXI_BRESP != 2'b00);
                    w_state_nxt = w_last ? RD_REQ : WR_REQ;
                end
            end
            RD_REQ: begin
                m_axi.M_AXI_ARVALID = 1'b1;
                m_axi.M_AXI_ARADDR  = w_addr;
                if (m_axi.M_AXI_ARREADY) begin
                    w_state_nxt = RD_RESP;
                end
            end
            RD_RESP: begin
                m_axi.M_AXI_RREADY = 1'b1;
                if (m_axi.M_AXI_RVALID) begin
                    // A bad response and bad data on one beat count once
                    w_err_inc   = (m_axi.M_AXI_RRESP != 2'b00) ||
                                  (m_axi.M_AXI_RDATA != w_exp_data);
                    w_state_nxt = w_last ? FINISH : RD_REQ;
                end
            end
            FINISH: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_index     <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_err_count <= 8'h00;
            r_busy      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            if (w_err_inc && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_index     <= '0;
                        r_err_count <= 8'h00;
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                    end
                end
                WR_REQ: begin
                    if (w_wr_both) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        if (w_aw_hs) r_aw_done <= 1'b1;
                        if (w_w_hs)  r_w_done  <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (m_axi.M_AXI_BVALID) begin
                        r_index <= w_last ? '0 : r_index + c_IDX_ONE;
                    end
                end
                RD_RESP: begin
                    if (m_axi.M_AXI_RVALID) begin
                        r_index <= w_last ? '0 : r_index + c_IDX_ONE;
                    end
                end
                FINISH: begin
                    // The final read beat has already been folded in
                    r_busy <= 1'b0;
                    r_pass <= (r_err_count == 8'h00);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axil_seq_tester.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axil_seq_tester
//  Purpose  : Directed self-checking bench for axil_seq_tester. Instance A
//             (NUM_REGS=4) talks to a small RAM slave with selectable
//             misbehaviour; instance B (NUM_REGS=256) talks to a slave that
//             answers every transfer with SLVERR.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axil_seq_tester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       aresetn_a, aresetn_b, start_a, start_b;
    logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [7:0] err_a, err_b;

    axil_seq_tester_if if_a ();
    axil_seq_tester_if if_b ();

    axil_seq_tester #(
        .NUM_REGS  (4),
        .BASE_ADDR (32'h0000_0000),
        .SEED      (32'h0000_0001)
    ) u_dut_a (
        .ACLK      (clk),
        .ARESETN   (aresetn_a),
        .start     (start_a),
        .busy      (busy_a),
        .done      (done_a),
        .pass      (pass_a),
        .err_count (err_a),
        .m_axi     (if_a)
    );

    axil_seq_tester #(
        .NUM_REGS  (256),
        .BASE_ADDR (32'h0000_0000),
        .SEED      (32'h0000_0001)
    ) u_dut_b (
        .ACLK      (clk),
        .ARESETN   (aresetn_b),
        .start     (start_b),
        .busy      (busy_b),
        .done      (done_b),
        .pass      (pass_b),
        .err_count (err_b),
        .m_axi     (if_b)
    );

    // ------------------------------------------------------------------
    // Slave A: RAM with optional slow AWREADY, bad data at 0x8, SLVERR
    // ------------------------------------------------------------------
    logic        mode_aw_slow = 1'b0;
    logic        mode_bad8    = 1'b0;
    logic        mode_err     = 1'b0;
    logic        clr_mem      = 1'b0;
    logic [31:0] mem    [0:15];
    int          wr_cnt [0:15];
    logic [3:0]  aw_dly;
    logic        aw_have, w_have;
    logic [31:0] aw_q, w_q;

    assign if_a.M_AXI_AWREADY = mode_aw_slow ? (aw_dly == 4'd3) : 1'b1;
    assign if_a.M_AXI_WREADY  = 1'b1;
    assign if_a.M_AXI_ARREADY = 1'b1;

    always @(posedge clk) begin : slave_a
        logic        aw_hs, w_hs;
        logic [31:0] a, d;
        aw_hs = if_a.M_AXI_AWVALID && if_a.M_AXI_AWREADY;
        w_hs  = if_a.M_AXI_WVALID  && if_a.M_AXI_WREADY;
        if (clr_mem) begin
            for (int i = 0; i < 16; i++) begin
                mem[i]    <= 32'h0;
                wr_cnt[i] <= 0;
            end
        end
        if (!aresetn_a) begin
            aw_have            <= 1'b0;
            w_have             <= 1'b0;
            aw_dly             <= 4'd0;
            if_a.M_AXI_BVALID  <= 1'b0;
            if_a.M_AXI_RVALID  <= 1'b0;
        end else begin
            if (if_a.M_AXI_AWVALID && !if_a.M_AXI_AWREADY) aw_dly <= aw_dly + 4'd1;
            else                                           aw_dly <= 4'd0;
            if (if_a.M_AXI_BVALID && if_a.M_AXI_BREADY) if_a.M_AXI_BVALID <= 1'b0;
            if (if_a.M_AXI_RVALID && if_a.M_AXI_RREADY) if_a.M_AXI_RVALID <= 1'b0;
            if (aw_hs) begin
                aw_have <= 1'b1;
                aw_q    <= if_a.M_AXI_AWADDR;
            end
            if (w_hs) begin
                w_have <= 1'b1;
                w_q    <= if_a.M_AXI_WDATA;
            end
            if ((aw_have || aw_hs) && (w_have || w_hs)) begin
                a = aw_hs ? if_a.M_AXI_AWADDR : aw_q;
                d = w_hs  ? if_a.M_AXI_WDATA  : w_q;
                mem[a[5:2]]       <= d;
                wr_cnt[a[5:2]]    <= wr_cnt[a[5:2]] + 1;
                aw_have           <= 1'b0;
                w_have            <= 1'b0;
                if_a.M_AXI_BVALID <= 1'b1;
                if_a.M_AXI_BRESP  <= mode_err ? 2'b10 : 2'b00;
            end
            if (if_a.M_AXI_ARVALID && if_a.M_AXI_ARREADY) begin
                a = if_a.M_AXI_ARADDR;
                if_a.M_AXI_RVALID <= 1'b1;
                if_a.M_AXI_RRESP  <= mode_err ? 2'b10 : 2'b00;
                if_a.M_AXI_RDATA  <= (mode_bad8 && a == 32'h8) ? 32'h0000_DEAD : mem[a[5:2]];
            end
        end
    end

    // Protocol monitor on A: AW/W held stable until accepted, and no read
    // issued while a write is still in flight.
    int          viol_a = 0;
    logic        p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
    logic [31:0] p_awaddr = 32'h0, p_wdata = 32'h0;

    always @(negedge clk) begin
        if (aresetn_a) begin
            if ((p_awv && !p_awr && (!if_a.M_AXI_AWVALID || if_a.M_AXI_AWADDR != p_awaddr)) ||
                (p_wv  && !p_wr  && (!if_a.M_AXI_WVALID  || if_a.M_AXI_WDATA  != p_wdata))  ||
                (if_a.M_AXI_ARVALID && (aw_have || w_have || if_a.M_AXI_BVALID)))
                viol_a <= viol_a + 1;
        end
        p_awv    <= aresetn_a && if_a.M_AXI_AWVALID;
        p_awr    <= if_a.M_AXI_AWREADY;
        p_wv     <= aresetn_a && if_a.M_AXI_WVALID;
        p_wr     <= if_a.M_AXI_WREADY;
        p_awaddr <= if_a.M_AXI_AWADDR;
        p_wdata  <= if_a.M_AXI_WDATA;
    end

    // ------------------------------------------------------------------
    // Slave B: zero-wait, every response SLVERR, read data always 0
    // ------------------------------------------------------------------
    assign if_b.M_AXI_AWREADY = 1'b1;
    assign if_b.M_AXI_WREADY  = 1'b1;
    assign if_b.M_AXI_ARREADY = 1'b1;
    assign if_b.M_AXI_BRESP   = 2'b10;
    assign if_b.M_AXI_RRESP   = 2'b10;
    assign if_b.M_AXI_RDATA   = 32'h0;

    always @(posedge clk) begin
        if (!aresetn_b) begin
            if_b.M_AXI_BVALID <= 1'b0;
            if_b.M_AXI_RVALID <= 1'b0;
        end else begin
            if (if_b.M_AXI_BVALID && if_b.M_AXI_BREADY) if_b.M_AXI_BVALID <= 1'b0;
            if (if_b.M_AXI_RVALID && if_b.M_AXI_RREADY) if_b.M_AXI_RVALID <= 1'b0;
            if (if_b.M_AXI_AWVALID && if_b.M_AXI_WVALID) if_b.M_AXI_BVALID <= 1'b1;
            if (if_b.M_AXI_ARVALID) if_b.M_AXI_RVALID <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        @(negedge clk);
        clr_mem = 1'b1;
        @(negedge clk);
        clr_mem = 1'b0;
    endtask

    // Pulses start on A and counts cycles up to the done pulse; returns at
    // the falling edge after FINISH, when pass/busy have settled.
    task automatic run_a(output int cycles, output logic saw_done, output logic busy1);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cycles  = 1;
        busy1   = busy_a;
        while (!done_a && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        saw_done = done_a;
        @(negedge clk);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("%s_mem%0d", tag, i), mem[i], 64'(i + 1));
            check_val($sformatf("%s_wrcnt%0d", tag, i), 64'(wr_cnt[i]), 64'd1);
        end
    endtask

    function automatic logic [4:0] a_handshakes();
        return {if_a.M_AXI_AWVALID, if_a.M_AXI_WVALID, if_a.M_AXI_BREADY,
                if_a.M_AXI_ARVALID, if_a.M_AXI_RREADY};
    endfunction

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int   cyc;
        int   waited;
        logic dn, b1, seen;
        logic [7:0] mid_err;

        aresetn_a = 1'b0;
        aresetn_b = 1'b0;
        start_a   = 1'b0;
        start_b   = 1'b0;
        repeat (3) @(negedge clk);

        check_val("rst_handshakes", a_handshakes(), 5'b0);
        check_val("rst_status", {busy_a, done_a, pass_a}, 3'b000);
        check_val("rst_err", err_a, 8'h00);
        check_val("rst_addr", {if_a.M_AXI_AWADDR, if_a.M_AXI_ARADDR}, 64'h0);
        check_val("rst_wdata", if_a.M_AXI_WDATA, 32'h0);

        aresetn_a = 1'b1;
        aresetn_b = 1'b1;
        repeat (3) @(negedge clk);
        check_val("idle_quiet", {a_handshakes(), busy_a, done_a}, 7'b0);
        check_val("prot_strb", {if_a.M_AXI_AWPROT, if_a.M_AXI_ARPROT, if_a.M_AXI_WSTRB},
                  {3'b000, 3'b000, 4'hF});

        // Zero-wait RAM: 4*4+1 cycles, all good
        clear_mem();
        run_a(cyc, dn, b1);
        check_val("zw_busy", b1, 1'b1);
        check_val("zw_done", dn, 1'b1);
        check_val("zw_cycles", 64'(cyc), 64'd17);
        check_val("zw_result", {busy_a, pass_a, err_a}, {1'b0, 1'b1, 8'h00});
        check_mem("zw");

        // WREADY three cycles ahead of AWREADY: 5 cycles per write
        mode_aw_slow = 1'b1;
        clear_mem();
        run_a(cyc, dn, b1);
        mode_aw_slow = 1'b0;
        check_val("slow_cycles", 64'(cyc), 64'd29);
        check_val("slow_result", {pass_a, err_a}, {1'b1, 8'h00});
        check_mem("slow");
        check_val("slow_proto", 64'(viol_a), 64'd0);

        // Wrong data at 0x8
        mode_bad8 = 1'b1;
        clear_mem();
        run_a(cyc, dn, b1);
        mode_bad8 = 1'b0;
        check_val("bad8_cycles", 64'(cyc), 64'd17);
        check_val("bad8_result", {pass_a, err_a}, {1'b0, 8'h01});

        // SLVERR on every response, correct data
        mode_err = 1'b1;
        clear_mem();
        run_a(cyc, dn, b1);
        mode_err = 1'b0;
        check_val("slverr_result", {pass_a, err_a}, {1'b0, 8'h08});
        check_mem("slverr");

        // Good run so pass is 1, then reset during RD_RESP
        clear_mem();
        run_a(cyc, dn, b1);
        check_val("pre_rst_pass", pass_a, 1'b1);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        waited  = 0;
        while (!if_a.M_AXI_RREADY && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check_val("reach_rd_resp", if_a.M_AXI_RREADY, 1'b1);
        aresetn_a = 1'b0;
        @(negedge clk);
        aresetn_a = 1'b1;
        check_val("midrst_handshakes", a_handshakes(), 5'b0);
        check_val("midrst_status", {busy_a, done_a, pass_a, err_a}, 11'h000);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen = seen | (|a_handshakes()) | done_a | busy_a;
        end
        check_val("midrst_quiet", seen, 1'b0);
        clear_mem();
        run_a(cyc, dn, b1);
        check_val("post_rst_cycles", 64'(cyc), 64'd17);
        check_val("post_rst_result", {pass_a, err_a}, {1'b1, 8'h00});
        check_val("final_proto", 64'(viol_a), 64'd0);

        // B: 256 registers, every transfer errors, stray starts mid-run
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cyc     = 1;
        mid_err = 8'h00;
        while (!done_b && cyc < 2000) begin
            start_b = ((cyc % 200) == 50);
            if (cyc == 700) mid_err = err_b;
            @(negedge clk);
            cyc++;
        end
        start_b = 1'b0;
        check_val("sat_done", done_b, 1'b1);
        check_val("sat_cycles", 64'(cyc), 64'd1025);
        check_val("sat_mid_err", mid_err, 8'hFF);
        @(negedge clk);
        check_val("sat_result", {busy_b, pass_b, err_b}, {1'b0, 1'b0, 8'hFF});
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | done_b | busy_b;
        end
        check_val("sat_no_rerun", seen, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected the sequence to finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
